mov_writeback: RTL and testbench

//  Writeback stage directly downstream of the 64-bit MOV delay pipeline.
//  - MOV pipe: 7 stages, no enable, no reset, carries data only.
//  - This block tracks the valid bit and destination register alongside that pipe.
//  - Captures each result as it emerges, buffers it, and drains it to the register-file write port with a ready handshake.
//  - Credit-based flow control: issue is throttled because the MOV pipe itself cannot stall.

---
 rtl/mov_pkg.sv | 19 +
 rtl/mov_wb_fifo.sv | 62 ++++++
 rtl/mov_writeback.sv | 129 ++++++++++++
 tb/tb_mov_writeback.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mov_pkg.sv
// Shared types and sizing for the MOV writeback stage.
package mov_pkg;
    localparam int XLEN           = 64;
    localparam int RAW            = 5;
    localparam int MOV_PIPE_DEPTH = 7;
    localparam int FIFO_DEPTH     = 4;
    localparam int PTR_W          = $clog2(FIFO_DEPTH);
    localparam int CNT_W          = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [RAW-1:0]  rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

    // Buffer pointers wrap naturally because FIFO_DEPTH is a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return p + PTR_W'(1);
    endfunction
endpackage

// File: rtl/mov_wb_fifo.sv
// Small synchronous FIFO of writeback entries. Push and pop in the same
// edge are allowed at any occupancy; the caller never pushes into a full
// FIFO without a simultaneous pop.
module mov_wb_fifo
    import mov_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  wb_entry_t        push_entry,
    input  logic             pop,
    output wb_entry_t        head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    wb_entry_t        mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_pop_s;

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = (count_r == CNT_W'(FIFO_DEPTH));
    assign empty = (count_r == CNT_W'(0));

    // A pop on an empty FIFO is ignored.
    always_comb begin
        do_pop_s = 1'b0;
        if (pop && !empty) begin
            do_pop_s = 1'b1;
        end else begin
            do_pop_s = 1'b0;
        end
    end

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= push_entry;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/mov_writeback.sv
// Writeback stage behind the 7-stage MOV delay pipe. Tracks valid/rd tags
// in lockstep with the data pipe, buffers results and drains them to the
// register file with a ready handshake. Issue is credit-throttled because
// the MOV pipe cannot stall.
// Optional build macro: MOV_WB_BYPASS_EN -- present a result straight from
// the pipe output when the buffer is empty (saves one cycle of latency).
module mov_writeback
    import mov_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    input  logic [RAW-1:0]  issue_rd,
    output logic            issue_ready,
    input  logic [XLEN-1:0] mov_data,
    output logic            rf_we,
    output logic [RAW-1:0]  rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    input  logic            rf_ready,
    output logic            busy,
    output logic            overflow
);
    localparam int LAST = MOV_PIPE_DEPTH - 1;

    logic [MOV_PIPE_DEPTH-1:0] tv_r;
    logic [RAW-1:0]            td_r [MOV_PIPE_DEPTH];
    logic [CNT_W-1:0]          credits_r;
    logic                      overflow_r;

    logic                      issue_acc_s;
    logic                      cap_valid_s;
    wb_entry_t                 cap_entry_s;
    logic                      fifo_push_s;
    logic                      fifo_pop_s;
    wb_entry_t                 fifo_head_s;
    logic                      fifo_full_s;
    logic                      fifo_empty_s;
    logic [CNT_W-1:0]          fifo_count_s;
    logic                      wr_hs_s;

    assign issue_ready = (credits_r < CNT_W'(FIFO_DEPTH));
    assign issue_acc_s = issue_valid && issue_ready;
    assign cap_valid_s = tv_r[LAST];
    assign cap_entry_s = '{rd: td_r[LAST], data: mov_data};
    assign busy        = (|tv_r) || (fifo_count_s != CNT_W'(0));
    assign overflow    = overflow_r;
    assign wr_hs_s     = rf_we && rf_ready;

    mov_wb_fifo u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push_s),
        .push_entry (cap_entry_s),
        .pop        (fifo_pop_s),
        .head       (fifo_head_s),
        .full       (fifo_full_s),
        .empty      (fifo_empty_s),
        .count      (fifo_count_s)
    );

    // Drain mux and capture decision; the bypass path only exists when enabled.
    always_comb begin
        rf_we       = 1'b0;
        rf_waddr    = fifo_head_s.rd;
        rf_wdata    = fifo_head_s.data;
        fifo_pop_s  = !fifo_empty_s && rf_ready;
        fifo_push_s = 1'b0;
`ifdef MOV_WB_BYPASS_EN
        if (fifo_empty_s && cap_valid_s) begin
            rf_we       = 1'b1;
            rf_waddr    = cap_entry_s.rd;
            rf_wdata    = cap_entry_s.data;
            fifo_push_s = !rf_ready;
        end else begin
            rf_we       = !fifo_empty_s;
            rf_waddr    = fifo_head_s.rd;
            rf_wdata    = fifo_head_s.data;
            fifo_push_s = cap_valid_s && (!fifo_full_s || fifo_pop_s);
        end
`else
        if (!fifo_empty_s) begin
            rf_we = 1'b1;
        end else begin
            rf_we = 1'b0;
        end
        fifo_push_s = cap_valid_s && (!fifo_full_s || fifo_pop_s);
`endif
    end

    // Tag pipe: shifts every edge alongside the MOV data pipe.
    always_ff @(posedge clk) begin
        if (rst) begin
            tv_r <= '0;
            for (int i = 0; i < MOV_PIPE_DEPTH; i++) begin
                td_r[i] <= '0;
            end
        end else begin
            tv_r    <= {tv_r[LAST-1:0], issue_acc_s};
            td_r[0] <= issue_rd;
            for (int i = 1; i < MOV_PIPE_DEPTH; i++) begin
                td_r[i] <= td_r[i-1];
            end
        end
    end

    // Credits count results in flight plus results buffered.
    always_ff @(posedge clk) begin
        if (rst) begin
            credits_r <= '0;
        end else begin
            case ({issue_acc_s, wr_hs_s})
                2'b10:   credits_r <= credits_r + CNT_W'(1);
                2'b01:   credits_r <= credits_r - CNT_W'(1);
                default: credits_r <= credits_r;
            endcase
        end
    end

    // Sticky flag for issues dropped for lack of credit.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_r <= 1'b0;
        end else if (issue_valid && !issue_ready) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end
endmodule

// File: tb/tb_mov_writeback.sv
// Self-checking bench for mov_writeback: queue-based reference model,
// per-cycle compare, directed scenarios and randomized traffic.
module tb_mov_writeback;
`ifdef MOV_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = 5'd0;
    logic [63:0] issue_data = 64'd0;
    logic        issue_ready;
    logic [63:0] mov_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic        rf_ready = 1'b1;
    logic        busy;
    logic        overflow;

    int errs = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    mov_writeback dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_ready(issue_ready), .mov_data(mov_data), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_ready(rf_ready),
        .busy(busy), .overflow(overflow)
    );

    // Environment: the 7-stage MOV data pipe (no enable, no reset)
    logic [63:0] pipe [7];
    always @(posedge clk) begin
        pipe[0] <= issue_data;
        for (int i = 1; i < 7; i++) pipe[i] <= pipe[i-1];
    end
    assign mov_data = pipe[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: accepted MOVs wait 7 edges, then join a 4-deep buffer
    typedef struct { logic [4:0] rd; logic [63:0] data; int due; } ent_t;
    ent_t infl[$];
    ent_t bq[$];
    bit   m_ovf = 1'b0;
    int   edges = 0;

    always @(posedge clk) begin
        int  e;
        bit  pend;
        bit  rdy;
        ent_t f;
        e = edges + 1;
        if (rst) begin
            infl.delete();
            bq.delete();
            m_ovf = 1'b0;
        end else begin
            rdy  = (infl.size() + bq.size()) < 4;
            pend = (infl.size() > 0) && (infl[0].due == e);
            if (bq.size() > 0) begin
                if (rf_ready) void'(bq.pop_front());
            end else if (BYP && pend && rf_ready) begin
                void'(infl.pop_front());
                pend = 1'b0;
            end
            if (pend) bq.push_back(infl.pop_front());
            if (issue_valid) begin
                if (rdy) begin
                    f.rd = issue_rd; f.data = issue_data; f.due = e + 7;
                    infl.push_back(f);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        edges = e;
    end

    // Per-cycle compare of all outputs against the model
    always @(negedge clk) begin
        bit   pend;
        bit   exp_we;
        ent_t h;
        if (chk_en) begin
            pend   = (infl.size() > 0) && (infl[0].due == edges + 1);
            exp_we = 1'b0;
            h.rd = 5'd0; h.data = 64'd0; h.due = 0;
            if (bq.size() > 0) begin
                exp_we = 1'b1; h = bq[0];
            end else if (BYP && pend) begin
                exp_we = 1'b1; h = infl[0];
            end
            check("rf_we", rf_we, exp_we);
            if (exp_we) begin
                check("rf_waddr", rf_waddr, h.rd);
                check("rf_wdata", rf_wdata, h.data);
            end
            check("issue_ready", issue_ready, (infl.size() + bq.size()) < 4);
            check("busy", busy, (infl.size() + bq.size()) > 0);
            check("overflow", overflow, m_ovf);
        end
    end

    // Log of completed register-file writes (address and cycle)
    logic [4:0] wlog[$];
    int         wcyc[$];
    always @(negedge clk) begin
        if (rf_we && rf_ready && !rst) begin
            wlog.push_back(rf_waddr);
            wcyc.push_back(edges);
        end
    end

    initial begin
        int first;
        int ncyc;
        int acc;
        logic [4:0]  wa;
        logic [63:0] wd;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_rf_we", rf_we, 1'b0);
        check("rst_issue_ready", issue_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_waddr", rf_waddr, 5'd0);
        check("rst_wdata", rf_wdata, 64'd0);
        chk_en = 1'b1;

        // 1: single MOV latency and contents
        @(negedge clk);
        rf_ready = 1'b1; issue_valid = 1'b1; issue_rd = 5'd3; issue_data = 64'h1111111111111111;
        @(posedge clk);
        @(negedge clk);
        issue_valid = 1'b0;
        first = -1; ncyc = 0; wa = 5'd0; wd = 64'd0;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge clk);
            if (rf_we) begin
                ncyc++;
                if (first < 0) begin first = k; wa = rf_waddr; wd = rf_wdata; end
            end
        end
        check("t1_latency", first, BYP ? 6 : 7);
        check("t1_we_cycles", ncyc, 1);
        check("t1_waddr", wa, 5'd3);
        check("t1_wdata", wd, 64'h1111111111111111);

        // 2: back-to-back rd=1..4, no backpressure
        wlog.delete(); wcyc.delete();
        for (int i = 0; i < 4; i++) begin
            issue_valid = 1'b1; issue_rd = 5'(i + 1); issue_data = {$urandom, $urandom};
            @(negedge clk);
        end
        issue_valid = 1'b0;
        repeat (14) @(negedge clk);
        check("t2_nwrites", wlog.size(), 4);
        if (wlog.size() == 4) begin
            for (int i = 0; i < 4; i++) check("t2_order", wlog[i], 5'(i + 1));
            check("t2_consecutive", wcyc[3] - wcyc[0], 3);
        end
        check("t2_ready", issue_ready, 1'b1);
        check("t2_busy", busy, 1'b0);

        // 3/4: full backpressure, credit limit, overflow
        wlog.delete(); wcyc.delete();
        rf_ready = 1'b0; acc = 0;
        for (int i = 0; i < 8; i++) begin
            issue_valid = 1'b1; issue_rd = 5'(i + 1); issue_data = {$urandom, $urandom};
            if (i == 4) check("t3_ready_5th", issue_ready, 1'b0);
            if (issue_ready) acc++;
            @(negedge clk);
        end
        issue_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("t3_accepted", acc, 4);
        check("t4_overflow_set", overflow, 1'b1);
        check("t3_no_write", wlog.size(), 0);
        rf_ready = 1'b1;
        repeat (8) @(negedge clk);
        check("t3_nwrites", wlog.size(), 4);
        if (wlog.size() == 4) begin
            for (int i = 0; i < 4; i++) check("t3_order", wlog[i], 5'(i + 1));
        end
        check("t4_overflow_sticky", overflow, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t4_overflow_clr", overflow, 1'b0);

        // 5: reset with three tags in flight
        for (int i = 0; i < 3; i++) begin
            issue_valid = 1'b1; issue_rd = 5'(10 + i); issue_data = {$urandom, $urandom};
            @(negedge clk);
        end
        issue_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wlog.delete(); wcyc.delete();
        repeat (10) @(negedge clk);
        check("t5_no_write", wlog.size(), 0);
        check("t5_ready", issue_ready, 1'b1);
        check("t5_busy", busy, 1'b0);

        // 6: buffer refilling while draining, push and pop on the same edge
        rf_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue_valid = 1'b1; issue_rd = 5'(5 + i); issue_data = {$urandom, $urandom};
            @(negedge clk);
        end
        issue_valid = 1'b0;
        repeat (6) @(negedge clk);
        rf_ready = 1'b1;
        repeat (8) @(negedge clk);
        check("t6_nwrites", wlog.size(), 4);
        if (wlog.size() == 4) begin
            for (int i = 0; i < 4; i++) check("t6_order", wlog[i], 5'(5 + i));
        end

        // Randomized traffic with occasional reset
        for (int c = 0; c < 3000; c++) begin
            issue_valid = ($urandom_range(0, 9) < 7);
            issue_rd    = 5'($urandom_range(0, 31));
            issue_data  = {$urandom, $urandom};
            rf_ready    = ($urandom_range(0, 9) < 6);
            rst         = ($urandom_range(0, 199) == 0);
            @(negedge clk);
        end
        issue_valid = 1'b0; rst = 1'b0; rf_ready = 1'b1;
        repeat (20) @(negedge clk);
        check("end_busy", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
